// File: rtl/fmcw_pkg.sv
// Shared constants for the FFT-to-ft245 frame packer: word tags, field
// placement helpers and the packer FSM encoding.
package fmcw_pkg;

    localparam int TAG_W = 4;

    localparam logic [TAG_W-1:0] TAG_FIRST  = 4'h1;
    localparam logic [TAG_W-1:0] TAG_MID    = 4'h2;
    localparam logic [TAG_W-1:0] TAG_LAST   = 4'h3;
    localparam logic [TAG_W-1:0] TAG_STATUS = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } pk_state_e;

    // Fields are packed from the MSB down; anything left at the bottom is zero.
    function automatic int tag_lsb(input int ww);
        return ww - TAG_W;
    endfunction

    function automatic int bin_lsb(input int ww, input int nw);
        return tag_lsb(ww) - nw;
    endfunction

    function automatic int re_lsb(input int ww, input int nw, input int dw);
        return bin_lsb(ww, nw) - dw;
    endfunction

    function automatic int im_lsb(input int ww, input int nw, input int dw);
        return re_lsb(ww, nw, dw) - dw;
    endfunction

    function automatic int fctr_lsb(input int ww, input int cw);
        return tag_lsb(ww) - cw;
    endfunction

    function automatic int dctr_lsb(input int ww, input int cw);
        return fctr_lsb(ww, cw) - cw;
    endfunction

endpackage

// File: rtl/fft_frame_packer_if.sv
// FFT sample input and ft245 write-port signals of the frame packer.
interface fft_frame_packer_if #(
    parameter int N_WIDTH    = 10,
    parameter int DATA_WIDTH = 25,
    parameter int WORD_WIDTH = 64
) ();
    logic                         fft_valid_i;
    logic [N_WIDTH-1:0]           fft_bin_i;
    logic signed [DATA_WIDTH-1:0] fft_re_i;
    logic signed [DATA_WIDTH-1:0] fft_im_i;
    logic                         wr_full_i;
    logic                         wr_en_o;
    logic [WORD_WIDTH-1:0]        wr_data_o;

    modport master (
        output fft_valid_i, fft_bin_i, fft_re_i, fft_im_i, wr_full_i,
        input  wr_en_o, wr_data_o
    );

    modport slave (
        input  fft_valid_i, fft_bin_i, fft_re_i, fft_im_i, wr_full_i,
        output wr_en_o, wr_data_o
    );
endinterface

// File: rtl/fft_frame_packer.sv
// Packs FFT bins into tagged 64-bit words for the ft245, drops frames that
// cannot be delivered intact and appends a cumulative status word per frame.
module fft_frame_packer
    import fmcw_pkg::*;
#(
    parameter int N          = 1024,
    parameter int N_WIDTH    = (N > 1) ? $clog2(N) : 1,
    parameter int DATA_WIDTH = 25,
    parameter int WORD_WIDTH = 64,
    parameter int CTR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_frame_packer_if.slave    bus,
    output logic [CTR_WIDTH-1:0] frame_ctr_o,
    output logic [CTR_WIDTH-1:0] drop_ctr_o
);

    localparam int TAG_LSB  = tag_lsb(WORD_WIDTH);
    localparam int BIN_LSB  = bin_lsb(WORD_WIDTH, N_WIDTH);
    localparam int RE_LSB   = re_lsb(WORD_WIDTH, N_WIDTH, DATA_WIDTH);
    localparam int IM_LSB   = im_lsb(WORD_WIDTH, N_WIDTH, DATA_WIDTH);
    localparam int FCTR_LSB = fctr_lsb(WORD_WIDTH, CTR_WIDTH);
    localparam int DCTR_LSB = dctr_lsb(WORD_WIDTH, CTR_WIDTH);
    localparam logic [N_WIDTH-1:0] LAST_BIN = N_WIDTH'(N - 1);

    if (TAG_W + N_WIDTH + 2 * DATA_WIDTH > WORD_WIDTH) begin : g_bad_bin_word
        $error("fft_frame_packer: bin word does not fit in WORD_WIDTH");
    end
    if (TAG_W + 2 * CTR_WIDTH > WORD_WIDTH) begin : g_bad_stat_word
        $error("fft_frame_packer: status word does not fit in WORD_WIDTH");
    end
    if ((N < 1) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("fft_frame_packer: N must be a power of two");
    end

    pk_state_e              state, state_d;
    logic [N_WIDTH-1:0]     exp_bin, exp_bin_d;
    logic                   status_pending;
    logic                   out_valid;
    logic [WORD_WIDTH-1:0]  out_word;
    logic [CTR_WIDTH-1:0]   frame_ctr, drop_ctr;

    logic                   wr_en, slot_free, is_first, is_last;
    logic                   bin_push, status_emit;
    logic                   frame_inc, drop_inc, set_pend;
    logic [TAG_W-1:0]       push_tag;
    logic [WORD_WIDTH-1:0]  bin_word, stat_word;

    assign wr_en     = out_valid & ~bus.wr_full_i;
    assign slot_free = ~out_valid | wr_en;
    assign is_first  = bus.fft_valid_i && (bus.fft_bin_i == '0);
    assign is_last   = bus.fft_bin_i == LAST_BIN;

    // Bin pushes always win; the status word waits for a cycle with no bin.
    assign status_emit = status_pending & slot_free & ~bin_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            exp_bin <= '0;
        end else begin
            state   <= state_d;
            exp_bin <= exp_bin_d;
        end
    end

    always_comb begin
        state_d   = state;
        exp_bin_d = exp_bin;
        bin_push  = 1'b0;
        push_tag  = TAG_MID;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
        set_pend  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (is_first) begin
                    frame_inc = 1'b1;
                    if (!slot_free) begin
                        drop_inc = 1'b1;
                        // A one-bin frame is already over, nothing to skip.
                        if (is_last) set_pend = 1'b1;
                        else         state_d  = ST_DROP;
                    end else if (is_last) begin
                        bin_push = 1'b1;
                        push_tag = TAG_LAST;
                        set_pend = 1'b1;
                    end else begin
                        bin_push  = 1'b1;
                        push_tag  = TAG_FIRST;
                        exp_bin_d = N_WIDTH'(1);
                        state_d   = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (bus.fft_valid_i) begin
                    if ((bus.fft_bin_i != exp_bin) || !slot_free) begin
                        drop_inc = 1'b1;
                        state_d  = ST_DROP;
                    end else if (is_last) begin
                        bin_push = 1'b1;
                        push_tag = TAG_LAST;
                        set_pend = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        bin_push  = 1'b1;
                        exp_bin_d = exp_bin + N_WIDTH'(1);
                    end
                end
            end
            ST_DROP: begin
                if (bus.fft_valid_i && is_last) begin
                    set_pend = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bin_word                          = '0;
        bin_word[TAG_LSB +: TAG_W]        = push_tag;
        bin_word[BIN_LSB +: N_WIDTH]      = bus.fft_bin_i;
        bin_word[RE_LSB +: DATA_WIDTH]    = bus.fft_re_i;
        bin_word[IM_LSB +: DATA_WIDTH]    = bus.fft_im_i;
        stat_word                         = '0;
        stat_word[TAG_LSB +: TAG_W]       = TAG_STATUS;
        stat_word[FCTR_LSB +: CTR_WIDTH]  = frame_ctr;
        stat_word[DCTR_LSB +: CTR_WIDTH]  = drop_ctr;
    end

    // Status carries the registered counters, i.e. before this cycle's bumps.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_pending <= 1'b0;
            out_valid      <= 1'b0;
            out_word       <= '0;
            frame_ctr      <= '0;
            drop_ctr       <= '0;
        end else begin
            status_pending <= set_pend | (status_pending & ~status_emit);
            if (frame_inc) frame_ctr <= frame_ctr + CTR_WIDTH'(1);
            if (drop_inc)  drop_ctr  <= drop_ctr + CTR_WIDTH'(1);
            if (bin_push) begin
                out_valid <= 1'b1;
                out_word  <= bin_word;
            end else if (status_emit) begin
                out_valid <= 1'b1;
                out_word  <= stat_word;
            end else if (wr_en) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.wr_en_o   = wr_en;
    assign bus.wr_data_o = out_word;
    assign frame_ctr_o   = frame_ctr;
    assign drop_ctr_o    = drop_ctr;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed scenarios with random bin payloads, checked against a word-list
// model of what the host should receive.
module tb_fft_frame_packer;
    localparam int N  = 1024;
    localparam int NW = 10;
    localparam int DW = 25;
    localparam int WW = 64;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic [CW-1:0] frame_ctr_o, drop_ctr_o;

    fft_frame_packer_if #(.N_WIDTH(NW), .DATA_WIDTH(DW), .WORD_WIDTH(WW)) bus ();

    fft_frame_packer #(
        .N(N), .N_WIDTH(NW), .DATA_WIDTH(DW), .WORD_WIDTH(WW), .CTR_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_ctr_o (frame_ctr_o),
        .drop_ctr_o  (drop_ctr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WW-1:0]         got_q[$];
    int                    got_cyc[$];
    logic [WW-1:0]         exp_q[$];
    logic signed [DW-1:0]  re_a[N];
    logic signed [DW-1:0]  im_a[N];
    int                    n_cmp = 0;
    int                    n_bad = 0;
    int                    dcyc, d0, dlast;

    // Host-side view: every cycle with wr_en high delivers one word.
    always @(negedge clk) begin
        if (bus.wr_en_o) begin
            got_q.push_back(bus.wr_data_o);
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [WW-1:0] mk_bin(input int k, input logic signed [DW-1:0] re,
                                             input logic signed [DW-1:0] im);
        logic [3:0]    t;
        logic [NW-1:0] b;
        t = (k == 0) ? 4'h1 : ((k == N - 1) ? 4'h3 : 4'h2);
        b = k[NW-1:0];
        return {t, b, re, im};
    endfunction

    function automatic logic [WW-1:0] mk_stat(input int f, input int d);
        logic [CW-1:0] fv, dv;
        fv = f[CW-1:0];
        dv = d[CW-1:0];
        return {4'hA, fv, dv, 28'h0};
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag);
        int n;
        n_cmp++;
        assert (got_q.size() == exp_q.size())
        else begin
            n_bad++;
            $error("FAIL %s_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic drive(input logic v, input int b, input logic signed [DW-1:0] re,
                         input logic signed [DW-1:0] im, input logic full);
        @(posedge clk);
        #1;
        bus.fft_valid_i = v;
        bus.fft_bin_i   = b[NW-1:0];
        bus.fft_re_i    = re;
        bus.fft_im_i    = im;
        bus.wr_full_i   = full;
        dcyc            = cyc;
    endtask

    task automatic send(input int k, input logic full);
        drive(1'b1, k, re_a[k], im_a[k], full);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, '0, '0, 1'b0);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < N; k++) begin
            re_a[k] = DW'($urandom);
            im_a[k] = DW'($urandom);
        end
    endtask

    task automatic expect_frame(input int nb);
        for (int k = 0; k < nb; k++) exp_q.push_back(mk_bin(k, re_a[k], im_a[k]));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.fft_valid_i = 1'b0;
        bus.wr_full_i   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic send_full_frame();
        for (int k = 0; k < N; k++) begin
            send(k, 1'b0);
            if (k == 0) d0 = dcyc;
        end
        dlast = dcyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.fft_valid_i = 1'b0;
        bus.fft_bin_i   = '0;
        bus.fft_re_i    = '0;
        bus.fft_im_i    = '0;
        bus.wr_full_i   = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_wr_en", bus.wr_en_o, 1'b0);
        chk("rst_wr_data", bus.wr_data_o, '0);
        chk("rst_frame_ctr", frame_ctr_o, '0);
        chk("rst_drop_ctr", drop_ctr_o, '0);

        // One clean frame, re=bin, im=-bin
        for (int k = 0; k < N; k++) begin
            re_a[k] = DW'(k);
            im_a[k] = DW'(-k);
        end
        send_full_frame();
        idle(4);
        expect_frame(N);
        exp_q.push_back(mk_stat(1, 0));
        if (got_cyc.size() == N + 1) begin
            chk("t1_lat_first", 64'(got_cyc[0]), 64'(d0 + 1));
            chk("t1_lat_last", 64'(got_cyc[N-1]), 64'(dlast + 1));
            chk("t1_lat_status", 64'(got_cyc[N]), 64'(dlast + 2));
        end
        check_q("t1");
        chk("t1_frame_ctr", frame_ctr_o, 16'd1);
        chk("t1_drop_ctr", drop_ctr_o, 16'd0);

        // FIFO full for 3 cycles at bin 500, then an intact frame
        do_reset();
        rand_frame();
        for (int k = 0; k < N; k++) send(k, (k >= 500) && (k < 503));
        idle(4);
        expect_frame(500);
        exp_q.push_back(mk_stat(1, 1));
        chk("t2_drop_ctr", drop_ctr_o, 16'd1);
        check_q("t2_drop");
        rand_frame();
        send_full_frame();
        idle(4);
        expect_frame(N);
        exp_q.push_back(mk_stat(2, 1));
        check_q("t2_next");
        chk("t2_frame_ctr", frame_ctr_o, 16'd2);

        // Bin sequence jumps 10 -> 12
        do_reset();
        rand_frame();
        for (int k = 0; k < N; k++) if (k != 11) send(k, 1'b0);
        dlast = dcyc;
        idle(4);
        expect_frame(11);
        exp_q.push_back(mk_stat(1, 1));
        if (got_cyc.size() == 12) chk("t3_status_cyc", 64'(got_cyc[11]), 64'(dlast + 2));
        check_q("t3");
        chk("t3_drop_ctr", drop_ctr_o, 16'd1);

        // Back-to-back frames, no idle gap
        do_reset();
        rand_frame();
        send_full_frame();
        expect_frame(N);
        rand_frame();
        send_full_frame();
        idle(4);
        expect_frame(N);
        exp_q.push_back(mk_stat(2, 0));
        check_q("t4");
        chk("t4_frame_ctr", frame_ctr_o, 16'd2);

        // Reset mid-frame at bin 300, input resumes at 301
        do_reset();
        rand_frame();
        for (int k = 0; k < 300; k++) send(k, 1'b0);
        @(posedge clk);
        #1;
        rst             = 1'b1;
        bus.fft_bin_i   = NW'(300);
        @(posedge clk);
        @(negedge clk);
        chk("t5_wr_en", bus.wr_en_o, 1'b0);
        chk("t5_wr_data", bus.wr_data_o, '0);
        chk("t5_frame_ctr", frame_ctr_o, '0);
        chk("t5_drop_ctr", drop_ctr_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 301; k < N; k++) send(k, 1'b0);
        idle(4);
        expect_frame(300);
        check_q("t5_partial");
        chk("t5_ignored_ctr", frame_ctr_o, '0);
        rand_frame();
        send_full_frame();
        idle(4);
        expect_frame(N);
        exp_q.push_back(mk_stat(1, 0));
        check_q("t5_next");

        // Frame counter wrap
        do_reset();
        @(posedge clk);
        #1;
        force dut.frame_ctr = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_ctr;
        @(negedge clk);
        chk("t6_preload", frame_ctr_o, 16'hFFFF);
        rand_frame();
        send_full_frame();
        idle(4);
        chk("t6_wrap", frame_ctr_o, 16'h0000);
        expect_frame(N);
        exp_q.push_back(mk_stat(0, 0));
        check_q("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
